vector_div_sequencer: RTL and testbench

- Sequences the final FlashAttention normalisation O = O_acc / l by time-multiplexing LANES shared integer divider lanes across a VEC_LEN-element vector.
- Accepts one vector and one scalar divisor, issues LANES-wide beats to the divider lanes, collects quotients in order and presents the completed output vector.
- Sits between the expmul/accumulate stage and the O writeback.

---
 rtl/vector_div_sequencer_pkg.sv | 29 ++
 rtl/vecdiv_zero_sat.sv | 26 ++
 rtl/vector_div_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_vector_div_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_div_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vector_div_sequencer_pkg
// Description : Shared types and constants for the vector divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package vector_div_sequencer_pkg;

    localparam int MAX_EMBEDDING_DIM = 64;
    localparam int INTEGER_WIDTH     = 16;
    localparam int LANES_DEFAULT     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2,
        OUT  = 2'd3
    } vecdiv_state_t;

    typedef logic [LANES_DEFAULT*INTEGER_WIDTH-1:0]     LANE_VEC_T;
    typedef logic [MAX_EMBEDDING_DIM*INTEGER_WIDTH-1:0] STAR_VECTOR_T;
    typedef STAR_VECTOR_T                               O_VECTOR_T;
    typedef STAR_VECTOR_T                               EXPMUL_VEC_QT;

    localparam logic [INTEGER_WIDTH-1:0] SAT_POS = {1'b0, {(INTEGER_WIDTH-1){1'b1}}};
    localparam logic [INTEGER_WIDTH-1:0] SAT_NEG = {1'b1, {(INTEGER_WIDTH-1){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/vecdiv_zero_sat.sv
`default_nettype none
// ============================================================================
// Module      : vecdiv_zero_sat
// Description : Per-element saturation used when the divisor is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module vecdiv_zero_sat
    import vector_div_sequencer_pkg::*;
#(
    parameter int VEC_LEN    = MAX_EMBEDDING_DIM,
    parameter int DATA_WIDTH = INTEGER_WIDTH
) (
    input  logic [VEC_LEN*DATA_WIDTH-1:0] i_vec,
    output logic [VEC_LEN*DATA_WIDTH-1:0] o_vec
);

    localparam logic [DATA_WIDTH-1:0] c_sat_pos = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] c_sat_neg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    for (genvar e = 0; e < VEC_LEN; e++) begin : g_elem
        assign o_vec[e*DATA_WIDTH +: DATA_WIDTH] =
            i_vec[e*DATA_WIDTH + DATA_WIDTH - 1] ? c_sat_neg : c_sat_pos;
    end

endmodule
`default_nettype wire

// File: rtl/vector_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vector_div_sequencer
// Description : Issues a vector to shared divider lanes in LANES-wide beats and
//               reassembles the quotients. VECDIV_PERF_CNT_EN adds perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_div_sequencer
    import vector_div_sequencer_pkg::*;
#(
    parameter int VEC_LEN    = MAX_EMBEDDING_DIM,
    parameter int DATA_WIDTH = INTEGER_WIDTH,
    parameter int LANES      = LANES_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vld_in,
    output logic                          rdy_out,
    input  logic [VEC_LEN*DATA_WIDTH-1:0] vec_in,
    input  logic [DATA_WIDTH-1:0]         divisor_in,
    output logic                          vld_out,
    input  logic                          rdy_in,
    output logic [VEC_LEN*DATA_WIDTH-1:0] vec_out,
`ifdef VECDIV_PERF_CNT_EN
    output logic [31:0]                   busy_cycles,
    output logic [15:0]                   zero_div_count,
`endif
    output logic                          div_vld_out,
    input  logic                          div_rdy_in,
    output logic [LANES*DATA_WIDTH-1:0]   div_num,
    output logic [DATA_WIDTH-1:0]         div_den,
    input  logic                          div_vld_in,
    output logic                          div_rdy_out,
    input  logic [LANES*DATA_WIDTH-1:0]   div_quot
);

    localparam int BEATS  = VEC_LEN / LANES;
    localparam int LANE_W = LANES * DATA_WIDTH;
    localparam int VEC_W  = VEC_LEN * DATA_WIDTH;
    localparam int CNT_W  = $clog2(BEATS + 1);

    vecdiv_state_t     state_q, state_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [DATA_WIDTH-1:0] den_q, den_d;
    logic [CNT_W-1:0]  issue_idx_q, issue_idx_d;
    logic [CNT_W-1:0]  coll_idx_q, coll_idx_d;
    logic              rdy_out_q, rdy_out_d;
    logic              vld_out_q, vld_out_d;
    logic              div_vld_out_q, div_vld_out_d;
    logic              div_rdy_out_q, div_rdy_out_d;
    logic [VEC_W-1:0]  vec_out_q, vec_out_d;
    logic [LANE_W-1:0] div_num_q, div_num_d;

    logic              w_accept;
    logic              w_issue;
    logic              w_collect;
    logic              w_out_hs;
    logic [CNT_W-1:0]  w_next_issue;
    logic [VEC_W-1:0]  w_sat_vec;
    logic [LANE_W-1:0] w_beat [BEATS];

    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        assign w_beat[b] = vec_q[b*LANE_W +: LANE_W];
    end

    // A returning beat with nothing outstanding is a lane protocol error and is dropped.
    assign w_accept     = vld_in && rdy_out_q;
    assign w_issue      = div_vld_out_q && div_rdy_in;
    assign w_collect    = div_rdy_out_q && div_vld_in && (coll_idx_q != issue_idx_q);
    assign w_out_hs     = vld_out_q && rdy_in;
    assign w_next_issue = issue_idx_q + CNT_W'(1);

    vecdiv_zero_sat #(
        .VEC_LEN    (VEC_LEN),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_zero_sat (
        .i_vec (vec_q),
        .o_vec (w_sat_vec)
    );

    always_comb begin
        state_d       = state_q;
        vec_d         = vec_q;
        den_d         = den_q;
        issue_idx_d   = issue_idx_q;
        coll_idx_d    = coll_idx_q;
        rdy_out_d     = rdy_out_q;
        vld_out_d     = vld_out_q;
        div_vld_out_d = div_vld_out_q;
        div_rdy_out_d = div_rdy_out_q;
        vec_out_d     = vec_out_q;
        div_num_d     = div_num_q;
        case (state_q)
            IDLE: begin
                rdy_out_d = 1'b1;
                if (w_accept) begin
                    vec_d       = vec_in;
                    den_d       = divisor_in;
                    rdy_out_d   = 1'b0;
                    issue_idx_d = '0;
                    coll_idx_d  = '0;
                    if (divisor_in == '0) begin
                        state_d = ZERO;
                    end else begin
                        state_d       = RUN;
                        div_vld_out_d = 1'b1;
                        div_rdy_out_d = 1'b1;
                        div_num_d     = vec_in[LANE_W-1:0];
                    end
                end
            end
            RUN: begin
                if (w_issue) begin
                    issue_idx_d = w_next_issue;
                    if (w_next_issue == CNT_W'(BEATS)) begin
                        div_vld_out_d = 1'b0;
                    end else begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (w_next_issue == CNT_W'(b)) div_num_d = w_beat[b];
                        end
                    end
                end
                if (w_collect) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (coll_idx_q == CNT_W'(b)) vec_out_d[b*LANE_W +: LANE_W] = div_quot;
                    end
                    coll_idx_d = coll_idx_q + CNT_W'(1);
                    if (coll_idx_q == CNT_W'(BEATS - 1)) begin
                        state_d       = OUT;
                        vld_out_d     = 1'b1;
                        div_rdy_out_d = 1'b0;
                    end
                end
            end
            ZERO: begin
                vec_out_d = w_sat_vec;
                vld_out_d = 1'b1;
                state_d   = OUT;
            end
            OUT: begin
                if (w_out_hs) begin
                    vld_out_d = 1'b0;
                    rdy_out_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            vec_q         <= '0;
            den_q         <= '0;
            issue_idx_q   <= '0;
            coll_idx_q    <= '0;
            rdy_out_q     <= 1'b0;
            vld_out_q     <= 1'b0;
            div_vld_out_q <= 1'b0;
            div_rdy_out_q <= 1'b0;
            vec_out_q     <= '0;
            div_num_q     <= '0;
        end else begin
            state_q       <= state_d;
            vec_q         <= vec_d;
            den_q         <= den_d;
            issue_idx_q   <= issue_idx_d;
            coll_idx_q    <= coll_idx_d;
            rdy_out_q     <= rdy_out_d;
            vld_out_q     <= vld_out_d;
            div_vld_out_q <= div_vld_out_d;
            div_rdy_out_q <= div_rdy_out_d;
            vec_out_q     <= vec_out_d;
            div_num_q     <= div_num_d;
        end
    end

    assign rdy_out     = rdy_out_q;
    assign vld_out     = vld_out_q;
    assign vec_out     = vec_out_q;
    assign div_vld_out = div_vld_out_q;
    assign div_rdy_out = div_rdy_out_q;
    assign div_num     = div_num_q;
    assign div_den     = den_q;

    a_no_orphan_quot: assert property (@(posedge clk) disable iff (!rst)
        !(div_rdy_out_q && div_vld_in && (coll_idx_q == issue_idx_q)));

`ifdef VECDIV_PERF_CNT_EN
    logic [31:0] busy_q, busy_d;
    logic [15:0] zdc_q, zdc_d;

    // The accept cycle itself counts as the first busy cycle of the job.
    always_comb begin
        busy_d = busy_q;
        zdc_d  = zdc_q;
        if (state_q == IDLE) begin
            if (w_accept) busy_d = 32'd1;
        end else if (busy_q != '1) begin
            busy_d = busy_q + 32'd1;
        end
        if ((state_q == IDLE) && w_accept && (divisor_in == '0) && (zdc_q != '1)) begin
            zdc_d = zdc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            zdc_q  <= '0;
        end else begin
            busy_q <= busy_d;
            zdc_q  <= zdc_d;
        end
    end

    assign busy_cycles    = busy_q;
    assign zero_div_count = zdc_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vector_div_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vector_div_sequencer
// Description : Self-checking bench with a latency-D lane model and a
//               reference model for quotients, saturation and timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_div_sequencer;

    localparam int VEC_LEN    = 8;
    localparam int DW         = 16;
    localparam int LANES      = 4;
    localparam int BEATS      = VEC_LEN / LANES;
    localparam int VW         = VEC_LEN * DW;
    localparam int LW         = LANES * DW;
    localparam int STALL_FROM = 2;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          vld_in     = 1'b0;
    logic          rdy_in     = 1'b0;
    logic [VW-1:0] vec_in     = '0;
    logic [DW-1:0] divisor_in = '0;
    logic          div_rdy_in = 1'b1;
    logic          div_vld_in = 1'b0;
    logic [LW-1:0] div_quot   = '0;
    logic          rdy_out, vld_out, div_vld_out, div_rdy_out;
    logic [VW-1:0] vec_out;
    logic [LW-1:0] div_num;
    logic [DW-1:0] div_den;
`ifdef VECDIV_PERF_CNT_EN
    logic [31:0]   busy_cycles;
    logic [15:0]   zero_div_count;
`endif

    vector_div_sequencer #(
        .VEC_LEN    (VEC_LEN),
        .DATA_WIDTH (DW),
        .LANES      (LANES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .vld_in         (vld_in),
        .rdy_out        (rdy_out),
        .vec_in         (vec_in),
        .divisor_in     (divisor_in),
        .vld_out        (vld_out),
        .rdy_in         (rdy_in),
        .vec_out        (vec_out),
`ifdef VECDIV_PERF_CNT_EN
        .busy_cycles    (busy_cycles),
        .zero_div_count (zero_div_count),
`endif
        .div_vld_out    (div_vld_out),
        .div_rdy_in     (div_rdy_in),
        .div_num        (div_num),
        .div_den        (div_den),
        .div_vld_in     (div_vld_in),
        .div_rdy_out    (div_rdy_out),
        .div_quot       (div_quot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] vec;
        logic [DW-1:0] den;
        int            lane_lat;
        int            stall_len;
        int            out_stall;
        logic [VW-1:0] exp_vec;
        int            exp_lat;
    } job_t;

    int            checks    = 0;
    int            errors    = 0;
    int            cyc       = 0;
    int            job_base  = 0;
    int            lane_lat  = 3;
    int            stall_len = 0;
    int            issued    = 0;
    int            cur_beats = 0;
    int            zero_jobs = 0;
    bit            in_job    = 1'b0;
    logic [VW-1:0] cur_vec   = '0;
    logic [DW-1:0] cur_den   = '0;
    logic [LW-1:0] q_data[$];
    int            q_time[$];

    function automatic logic [VW-1:0] pk(input int e0, input int e1, input int e2, input int e3,
                                         input int e4, input int e5, input int e6, input int e7);
        logic [VW-1:0] v;
        int e[8];
        e = '{e0, e1, e2, e3, e4, e5, e6, e7};
        for (int i = 0; i < 8; i++) v[i*DW +: DW] = DW'(e[i]);
        return v;
    endfunction

    // Reference result: truncating division, or saturation by sign when dividing by zero.
    function automatic logic [VW-1:0] ref_vec(input logic [VW-1:0] v, input logic [DW-1:0] den);
        logic [VW-1:0] r;
        int x, d, q;
        d = int'($signed(den));
        for (int i = 0; i < VEC_LEN; i++) begin
            x = int'($signed(v[i*DW +: DW]));
            if (d == 0) q = (x < 0) ? -32768 : 32767;
            else        q = x / d;
            r[i*DW +: DW] = DW'(q);
        end
        return r;
    endfunction

    function automatic int ref_lat(input logic [DW-1:0] den, input int d_lat, input int stall);
        int t;
        if (den == '0) return 2;
        t = 0;
        for (int k = 0; k < BEATS; k++) begin
            t = t + 1;
            while (t >= STALL_FROM && t < STALL_FROM + stall) t = t + 1;
        end
        return t + d_lat + 1;
    endfunction

    function automatic logic [LW-1:0] lane_div(input logic [LW-1:0] num, input logic [DW-1:0] den);
        logic [LW-1:0] r;
        for (int l = 0; l < LANES; l++) begin
            r[l*DW +: DW] = DW'(int'($signed(num[l*DW +: DW])) / int'($signed(den)));
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // One clock: record handshakes of the ending cycle, then drive the lane side.
    task automatic step();
        int rel;
        if (div_vld_out && div_rdy_in) begin
            q_data.push_back(lane_div(div_num, div_den));
            q_time.push_back(cyc + lane_lat);
            issued++;
        end
        if (div_vld_in && div_rdy_out && q_time.size() > 0) begin
            void'(q_data.pop_front());
            void'(q_time.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
        rel = cyc - job_base;
        div_rdy_in = !(in_job && rel >= STALL_FROM && rel < STALL_FROM + stall_len);
        if (q_time.size() > 0 && q_time[0] <= cyc) begin
            div_vld_in = 1'b1;
            div_quot   = q_data[0];
        end else begin
            div_vld_in = 1'b0;
            div_quot   = {$urandom, $urandom};
        end
        if (in_job && issued < cur_beats && rel >= 1) chk("beat_vld", div_vld_out, 1'b1);
        if (div_vld_out) begin
            if (issued < cur_beats) begin
                chk("beat_data", {div_num, div_den}, {cur_vec[issued*LW +: LW], cur_den});
            end else begin
                checks++;
                errors++;
                $display("FAIL spurious_beat got div_vld_out=1 required 0 (cycle %0d)", cyc);
            end
        end
    endtask

    task automatic run_job(input job_t j);
        int lat;
        logic [VW-1:0] held;
        lat = -1;
        for (int n = 0; n < 20 && !rdy_out; n++) step();
        chk("rdy_out_idle", rdy_out, 1'b1);
        cur_vec   = j.vec;
        cur_den   = j.den;
        cur_beats = (j.den == '0) ? 0 : BEATS;
        issued    = 0;
        lane_lat  = j.lane_lat;
        stall_len = j.stall_len;
        if (j.den == '0) zero_jobs++;
        vec_in     = j.vec;
        divisor_in = j.den;
        vld_in     = 1'b1;
        rdy_in     = 1'b0;
        job_base   = cyc;
        in_job     = 1'b1;
        step();
        vld_in     = 1'b0;
        vec_in     = {$urandom, $urandom, $urandom, $urandom};
        divisor_in = DW'($urandom);
        chk("rdy_out_busy", rdy_out, 1'b0);
        for (int n = 0; n < 200; n++) begin
            if (vld_out) begin
                lat = cyc - job_base;
                break;
            end
            step();
        end
        in_job = 1'b0;
        chk_int("latency", lat, j.exp_lat);
        chk("vec_out", vec_out, j.exp_vec);
        held = vec_out;
        for (int k = 0; k < j.out_stall; k++) begin
            step();
            chk("stall_vld_out", vld_out, 1'b1);
            chk("stall_vec_out", vec_out, held);
            chk("stall_rdy_out", rdy_out, 1'b0);
        end
        rdy_in = 1'b1;
        step();
        rdy_in = 1'b0;
        chk("post_handshake", {rdy_out, vld_out}, 2'b10);
        chk_int("beats_issued", issued, cur_beats);
`ifdef VECDIV_PERF_CNT_EN
        chk_int("busy_cycles", int'(busy_cycles), lat + j.out_stall + 1);
        chk_int("zero_div_count", int'(zero_div_count), zero_jobs);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        job_t tbl[6];
        job_t j;
        logic [VW-1:0] v100, v25;

        tbl[0] = '{pk(10, 20, 30, 40, 50, 60, 70, 80), DW'(10), 3, 0, 0,
                   pk(1, 2, 3, 4, 5, 6, 7, 8), 6};
        tbl[1] = '{pk(10, 20, 30, 40, 50, 60, 70, 80), DW'(10), 3, 5, 0,
                   pk(1, 2, 3, 4, 5, 6, 7, 8), 11};
        tbl[2] = '{pk(5, -3, 0, 7, -1, 1, -32768, 32767), DW'(0), 3, 0, 0,
                   pk(32767, -32768, 32767, 32767, -32768, 32767, -32768, 32767), 2};
        tbl[3] = '{pk(-7, 7, -8, 9, 100, -100, 1, 0), DW'(3), 3, 0, 10,
                   pk(-2, 2, -2, 3, 33, -33, 0, 0), 6};
        tbl[4] = '{pk(1000, -1000, 32767, -32768, 5, -5, 6, -6), DW'(-2), 1, 0, 0,
                   pk(-500, 500, -16383, 16384, -2, 2, -3, 3), 4};
        tbl[5] = '{pk(10, 20, 30, 40, 50, 60, 70, 80), DW'(7), 6, 0, 0,
                   pk(1, 2, 4, 5, 7, 8, 10, 11), 9};

        #2 rst = 1'b0;
        #1;
        chk("rst_vec_out", vec_out, '0);
        chk("rst_ctrl", {rdy_out, vld_out, div_vld_out, div_rdy_out}, 4'b0000);
        chk("rst_div_bus", {div_num, div_den}, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step();
        chk("rdy_out_after_rst", rdy_out, 1'b1);

        for (int i = 0; i < 6; i++) run_job(tbl[i]);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < VEC_LEN; i++) j.vec[i*DW +: DW] = DW'($urandom);
            case ($urandom_range(0, 3))
                0:       j.den = '0;
                1:       j.den = DW'($urandom_range(1, 20));
                2:       j.den = DW'(-int'($urandom_range(1, 20)));
                default: j.den = DW'($urandom);
            endcase
            if (j.den == '0 && $urandom_range(0, 1) == 1) j.den = DW'(1);
            j.lane_lat  = int'($urandom_range(1, 5));
            j.stall_len = int'($urandom_range(0, 4));
            j.out_stall = int'($urandom_range(0, 3));
            j.exp_vec   = ref_vec(j.vec, j.den);
            j.exp_lat   = ref_lat(j.den, j.lane_lat, j.stall_len);
            run_job(j);
        end

        // Reset while a job is in flight, then confirm a clean restart.
        cur_vec   = pk(11, 22, 33, 44, 55, 66, 77, 88);
        cur_den   = DW'(3);
        cur_beats = BEATS;
        issued    = 0;
        lane_lat  = 3;
        stall_len = 0;
        vec_in     = cur_vec;
        divisor_in = cur_den;
        vld_in     = 1'b1;
        job_base   = cyc;
        in_job     = 1'b1;
        step();
        vld_in = 1'b0;
        step();
        chk_int("mid_run_issued", issued, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_vec_out", vec_out, '0);
        chk("mid_rst_ctrl", {rdy_out, vld_out, div_vld_out, div_rdy_out}, 4'b0000);
        chk("mid_rst_div_bus", {div_num, div_den}, '0);
        in_job    = 1'b0;
        cur_beats = 0;
        issued    = 0;
        q_data.delete();
        q_time.delete();
        div_vld_in = 1'b0;
        zero_jobs  = 0;
        step();
        rst = 1'b1;
        step();
        chk("rdy_out_after_mid_rst", rdy_out, 1'b1);
        v100 = pk(100, 100, 100, 100, 100, 100, 100, 100);
        v25  = pk(25, 25, 25, 25, 25, 25, 25, 25);
        j = '{v100, DW'(4), 3, 0, 0, v25, 6};
        run_job(j);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
